writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter SQUASH_CYCLES, default 3, the cycles discarded after a PC redirect (the instructions in flight in stages 0-2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port valid_in, input, 1, stage-2 result present this cycle.
REQ-005 SHALL have port pc_in, input, 16, pc_follow of the committing instruction.
REQ-006 SHALL have port op_cc_in, input, 7, {opcode[4:0], cc[1:0]} from stage 2.
REQ-007 SHALL have port dest_in, input, 4, destination register index.
REQ-008 SHALL have port value_in, input, 16, ALU/load result.
REQ-009 SHALL have ports rd_addr_a and rd_addr_b, input, 4 each, register read addresses.
REQ-010 SHALL have ports rd_data_a and rd_data_b, output, 16 each, combinational register read data.
REQ-011 SHALL have port z_out, output, 1, the condition flag Z.
REQ-012 SHALL have ports redirect (output, 1) and redirect_pc (output, 16): PC-write notification and target.
REQ-013 SHALL have port squash, output, 1, instructs upstream stages to discard their contents.
REQ-014 SHALL have port halt_out, output, 1, sticky halted indication.
REQ-015 SHALL have port retired_count, output, 16, count of committed instructions.

Function
REQ-016 SHALL implement states RUN, SQUASH and HALTED, plus a 16x16 register file.
REQ-017 SHALL define commit as: valid_in=1 and state RUN.
REQ-018 SHALL define a writing opcode as any opcode 00000-10010 except OPSTR (01111); OPSYS, OPNOP, OPPRE and the unused codes 10101-10111 never write.
REQ-019 On a commit of a writing opcode, SHALL write value_in to register dest_in at the clock edge.
REQ-020 On a commit of a writing opcode with cc=S (01), SHALL set Z to (value_in==0); otherwise Z SHALL hold.
REQ-021 SHALL treat cc AL/NE/EQ identically, since conditional suppression happens in stage 0.
REQ-022 rd_data_x SHALL return value_in when rd_addr_x==dest_in and a writing commit occurs this cycle (bypass); otherwise it returns the stored register.
REQ-023 On a writing commit with dest_in=15, SHALL:
- pulse redirect for exactly one cycle with redirect_pc=value_in;
- enter SQUASH with a down-counter loaded with SQUASH_CYCLES.
REQ-024 In SQUASH, squash SHALL be 1; valid_in SHALL be ignored (no write, no Z update, no count, no bypass).
REQ-025 The counter SHALL decrement every cycle; at 0 the block SHALL return to RUN, so squash is high for exactly SQUASH_CYCLES cycles.
REQ-026 On commit of OPSYS in RUN, SHALL enter HALTED; halt_out SHALL be 1 from the next cycle until reset.
REQ-027 An OPSYS arriving during SQUASH SHALL be discarded.
REQ-028 HALTED SHALL ignore all inputs; the register file remains readable.
REQ-029 retired_count SHALL increment on every commit, including no-write opcodes and OPSYS, and wrap 0xFFFF->0x0000.
REQ-030 redirect, z_out, squash, halt_out and retired_count SHALL be registered outputs.

Reset
REQ-031 While reset=1, SHALL force:
- state RUN and squash counter 0;
- all 16 registers to 0x0000;
- Z, redirect, squash and halt_out to 0;
- redirect_pc and retired_count to 0x0000.
REQ-032 Reset SHALL act asynchronously and abort any in-progress SQUASH or HALTED state immediately.

Verification
REQ-033 Reset: pulse reset -> all outputs 0, rd_data_a for R3 = 0x0000.
REQ-034 Z update:
- ADD, cc=S, dest 2, value 0x0000 -> next cycle R2=0 and z_out=1;
- then MOV, cc=AL, dest 2, value 0x0005 -> R2=5 and z_out stays 1.
REQ-035 Bypass: same cycle valid MOV, dest 4, value 0x1234, with rd_addr_a=4 -> rd_data_a=0x1234 before the edge.
REQ-036 Redirect and squash:
- MOV, dest 15, value 0x0040 -> redirect=1 for one cycle, redirect_pc=0x0040, squash=1 for 3 cycles;
- ADD to R1 during those cycles is dropped;
- ADD to R1 in cycle 4 is written.
REQ-037 Halt:
- STR, dest 3 -> R3 unchanged, retired_count +1;
- then SYS -> halt_out=1 next cycle;
- later MOV to R5 is ignored and retired_count is frozen.
REQ-038 Reset mid-squash: assert reset during squash cycle 2 -> squash=0 immediately; the first valid ADD after deassertion commits.

Source files
------------

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits stage-2 results into a 16x16 register file, tracks the Z flag,
// issues PC redirects with an upstream squash window, and halts on a system opcode.
module writeback_stage #(
    parameter int SQUASH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [15:0] pc_in,
    input  logic [6:0]  op_cc_in,
    input  logic [3:0]  dest_in,
    input  logic [15:0] value_in,
    input  logic [3:0]  rd_addr_a,
    input  logic [3:0]  rd_addr_b,
    output logic [15:0] rd_data_a,
    output logic [15:0] rd_data_b,
    output logic        z_out,
    output logic        redirect,
    output logic [15:0] redirect_pc,
    output logic        squash,
    output logic        halt_out,
    output logic [15:0] retired_count
);

    localparam int CW = (SQUASH_CYCLES < 1) ? 1 : $clog2(SQUASH_CYCLES + 1);

    localparam logic [4:0] OPSTR       = 5'b01111;
    localparam logic [4:0] OPSYS       = 5'b10011;
    localparam logic [4:0] LAST_WRITER = 5'b10010;
    localparam logic [1:0] CC_S        = 2'b01;

    typedef enum logic [1:0] {
        RUN,
        SQUASH,
        HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] regs_q [16];
    logic        z_q, z_d;
    logic        redirect_q, redirect_d;
    logic [15:0] redirect_pc_q, redirect_pc_d;
    logic        squash_q, halt_q;
    logic [15:0] count_q, count_d;
    logic        wr_en;

    logic [4:0]  opcode;
    logic [1:0]  cc;
    logic        is_writer;
    logic        unused_pc;

    assign opcode    = op_cc_in[6:2];
    assign cc        = op_cc_in[1:0];
    assign is_writer = (opcode <= LAST_WRITER) && (opcode != OPSTR);
    assign unused_pc = ^pc_in;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        z_d           = z_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        count_d       = count_q;
        wr_en         = 1'b0;
        case (state_q)
            RUN: begin
                if (valid_in) begin
                    count_d = count_q + 16'd1;
                    if (is_writer) begin
                        wr_en = 1'b1;
                        if (cc == CC_S) begin
                            z_d = (value_in == 16'h0000);
                        end
                        if (dest_in == 4'd15) begin
                            redirect_d    = 1'b1;
                            redirect_pc_d = value_in;
                            if (SQUASH_CYCLES > 0) begin
                                state_d = SQUASH;
                                cnt_d   = CW'(SQUASH_CYCLES);
                            end
                        end
                    end else if (opcode == OPSYS) begin
                        state_d = HALTED;
                    end
                end
            end
            // Leaving when the counter would hit zero keeps squash high for exactly SQUASH_CYCLES.
            SQUASH: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            z_q           <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 16'h0000;
            squash_q      <= 1'b0;
            halt_q        <= 1'b0;
            count_q       <= 16'h0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            z_q           <= z_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            squash_q      <= (state_d == SQUASH);
            halt_q        <= (state_d == HALTED);
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (wr_en) begin
            regs_q[dest_in] <= value_in;
        end
    end

    // Same-cycle bypass so stage 2 sees the value being committed right now.
    assign rd_data_a = (wr_en && rd_addr_a == dest_in) ? value_in : regs_q[rd_addr_a];
    assign rd_data_b = (wr_en && rd_addr_b == dest_in) ? value_in : regs_q[rd_addr_b];

    assign z_out         = z_q;
    assign redirect      = redirect_q;
    assign redirect_pc   = redirect_pc_q;
    assign squash        = squash_q;
    assign halt_out      = halt_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic
// compared against an abstract model of the commit / squash / halt rules.
module tb_writeback_stage;

    localparam int SQ = 3;
    localparam logic [4:0] ADD = 5'd0;
    localparam logic [4:0] MOV = 5'd1;
    localparam logic [4:0] STR = 5'd15;
    localparam logic [4:0] SYS = 5'd19;
    localparam logic [1:0] AL  = 2'b00;
    localparam logic [1:0] S   = 2'b01;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [15:0] pc_in;
    logic [6:0]  op_cc_in;
    logic [3:0]  dest_in;
    logic [15:0] value_in;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [15:0] rd_data_a, rd_data_b;
    logic        z_out, redirect, squash, halt_out;
    logic [15:0] redirect_pc, retired_count;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] mRegs [16];
    logic        mZ, mRedirect, mHalted;
    logic [15:0] mRedirectPc, mRetired;
    int          mSquashLeft;

    writeback_stage #(.SQUASH_CYCLES(SQ)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in),
        .op_cc_in(op_cc_in), .dest_in(dest_in), .value_in(value_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .z_out(z_out),
        .redirect(redirect), .redirect_pc(redirect_pc), .squash(squash),
        .halt_out(halt_out), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic isWriting(input logic [4:0] op);
        return (op <= 5'd18) && (op != STR);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mRegs[i] = 16'h0000;
        mZ = 1'b0; mRedirect = 1'b0; mHalted = 1'b0;
        mRedirectPc = 16'h0000; mRetired = 16'h0000; mSquashLeft = 0;
    endtask

    task automatic checkRegistered(input string where);
        checkOutput({where, ".z"}, 16'(z_out), 16'(mZ));
        checkOutput({where, ".redirect"}, 16'(redirect), 16'(mRedirect));
        checkOutput({where, ".redirectPc"}, redirect_pc, mRedirectPc);
        checkOutput({where, ".squash"}, 16'(squash), 16'(mSquashLeft > 0));
        checkOutput({where, ".halt"}, 16'(halt_out), 16'(mHalted));
        checkOutput({where, ".retired"}, retired_count, mRetired);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        valid_in = 1'b0;
        #1;
        modelReset();
        checkRegistered("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] op, input logic [1:0] cc,
                                 input logic [3:0] d, input logic [15:0] val,
                                 input logic [3:0] ra, input logic [3:0] rb);
        logic live, wr;
        logic [15:0] expA, expB;
        @(negedge clk);
        valid_in  = v;
        op_cc_in  = {op, cc};
        dest_in   = d;
        value_in  = val;
        rd_addr_a = ra;
        rd_addr_b = rb;
        pc_in     = 16'($urandom);
        live = v && (mSquashLeft == 0) && !mHalted;
        wr   = live && isWriting(op);
        expA = (wr && ra == d) ? val : mRegs[ra];
        expB = (wr && rb == d) ? val : mRegs[rb];
        #1;
        checkOutput("rdA", rd_data_a, expA);
        checkOutput("rdB", rd_data_b, expB);
        @(posedge clk);
        if (mSquashLeft > 0) mSquashLeft--;
        mRedirect = 1'b0;
        if (live) begin
            mRetired = mRetired + 16'd1;
            if (wr) begin
                mRegs[d] = val;
                if (cc == S) mZ = (val == 16'h0000);
                if (d == 4'd15) begin
                    mRedirect   = 1'b1;
                    mRedirectPc = val;
                    mSquashLeft = SQ;
                end
            end else if (op == SYS) begin
                mHalted = 1'b1;
            end
        end
        #1;
        checkRegistered("cycle");
    endtask

    initial begin
        reset = 1'b0; valid_in = 1'b0; pc_in = '0; op_cc_in = '0;
        dest_in = '0; value_in = '0; rd_addr_a = '0; rd_addr_b = '0;
        modelReset();

        // Reset state and R3 readback
        doReset();
        applyStimulus(0, ADD, AL, 0, 16'h0, 3, 3);
        checkOutput("resetR3", rd_data_a, 16'h0000);

        // Z update then hold
        applyStimulus(1, ADD, S, 2, 16'h0000, 2, 0);
        checkOutput("zSet", 16'(z_out), 16'd1);
        applyStimulus(1, MOV, AL, 2, 16'h0005, 2, 0);
        checkOutput("zHold", 16'(z_out), 16'd1);
        applyStimulus(0, ADD, AL, 0, 16'h0, 2, 2);
        checkOutput("r2Five", rd_data_a, 16'h0005);

        // Bypass
        applyStimulus(1, MOV, AL, 4, 16'h1234, 4, 4);

        // Redirect and squash window
        applyStimulus(1, MOV, AL, 15, 16'h0040, 0, 0);
        checkOutput("redirPulse", 16'(redirect), 16'd1);
        checkOutput("redirPc", redirect_pc, 16'h0040);
        for (int i = 0; i < SQ; i++) begin
            checkOutput("squashHigh", 16'(squash), 16'd1);
            applyStimulus(1, ADD, S, 1, 16'hDEAD, 1, 1);
        end
        checkOutput("squashLow", 16'(squash), 16'd0);
        applyStimulus(1, ADD, AL, 1, 16'h0777, 1, 1);
        applyStimulus(0, ADD, AL, 0, 16'h0, 1, 0);
        checkOutput("r1Written", rd_data_a, 16'h0777);

        // Store, halt, then frozen
        applyStimulus(1, MOV, AL, 3, 16'h0033, 3, 3);
        applyStimulus(1, STR, AL, 3, 16'hBEEF, 3, 3);
        applyStimulus(1, SYS, AL, 0, 16'h0000, 3, 3);
        checkOutput("haltSet", 16'(halt_out), 16'd1);
        applyStimulus(1, MOV, AL, 5, 16'h5555, 5, 3);
        applyStimulus(0, MOV, AL, 0, 16'h0, 5, 3);
        checkOutput("r5Ignored", rd_data_a, 16'h0000);
        checkOutput("r3Kept", rd_data_b, 16'h0033);

        // Reset in the middle of a squash window
        doReset();
        applyStimulus(1, MOV, AL, 15, 16'h0100, 0, 0);
        applyStimulus(1, ADD, AL, 1, 16'h1111, 1, 0);
        @(negedge clk);
        reset = 1'b1;
        valid_in = 1'b0;
        #1;
        modelReset();
        checkOutput("midSquashReset", 16'(squash), 16'd0);
        checkRegistered("midSquash");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1, ADD, AL, 1, 16'h2222, 1, 0);
        checkOutput("firstAfterReset", retired_count, 16'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [4:0] op;
            if (n % 150 == 149) doReset();
            op = 5'($urandom_range(0, 31));
            if (op == SYS && $urandom_range(0, 19) != 0) op = ADD;
            applyStimulus(1'($urandom_range(0, 3) != 0), op, 2'($urandom),
                          4'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                          4'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
